dcache_nway_array: RTL and testbench
====================================

Name: dcache_nway_array

Overview:
- Parametrised N-way set-associative data/tag array for the L1 data cache; next generation of the 2-way array.
- Sits between the dcache controller FSM and the off-chip memory interface.
- Adds true-LRU replacement over any power-of-two way count, explicit valid/dirty state, and registered responses with victim information.
- Adds a hardware flush sweep that streams dirty lines out for write-back.

Parameters:
- SETS, 16, number of sets (power of two, >=2)
- WAYS, 4, associativity (power of two, 2..8)
- TAG_W, 23, stored address-tag width
- LINE_W, 256, cache line width in bits

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- req_i  in  1  request strobe; accepted only when req_ready_o=1
- op_i  in  2  00 LOOKUP, 01 WRITE, 10 FILL, 11 no-op
- idx_i  in  log2(SETS)  set index
- tag_i  in  TAG_W  request tag
- data_i  in  LINE_W  line data for WRITE/FILL
- dirty_i  in  1  dirty value installed by FILL
- req_ready_o  out  1  0 while flush active
- rsp_valid_o  out  1  response valid, one cycle after accept
- hit_o  out  1  tag match on a valid way
- way_o  out  log2(WAYS)  hit way, or victim way on miss
- data_o  out  LINE_W  hit line, or victim line on miss
- victim_valid_o / victim_dirty_o  out  1 each  state of the victim line
- victim_tag_o  out  TAG_W  tag of the victim line
- flush_i  in  1  start flush sweep (pulse)
- flush_busy_o  out  1  sweep in progress
- flush_done_o  out  1  one-cycle pulse at sweep end
- evict_valid_o  out  1  dirty line presented for write-back
- evict_ready_i  in  1  consumer accepts the eviction
- evict_idx_o / evict_tag_o / evict_data_o  out  idx/TAG_W/LINE_W  evicted line

Behaviour:
- Reset:
  - All valid and dirty bits cleared; data storage is not reset.
  - Per-set LRU ages set to age[w]=WAYS-1-w, so way 0 is the first victim.
  - All outputs 0; FSM in IDLE.
- Hit:
  - hit = valid[w] && stored_tag[w]==tag_i. At most one way can match; FILL guarantees no duplicates.
- Victim:
  - Lowest-index invalid way.
  - If all ways are valid, the way with age WAYS-1.
- Latency:
  - Request accepted at edge N; response outputs registered and valid during cycle N+1; rsp_valid_o high for exactly one cycle.
  - One request per cycle, fully back-to-back.
  - A request in cycle N+1 observes array and LRU updates made at edge N.
- LOOKUP:
  - Hit: data_o = hit line, way_o = hit way.
  - Miss: data_o, victim_tag_o, victim_dirty_o, victim_valid_o and way_o describe the victim; no state change.
- WRITE:
  - Hit: line <- data_i, dirty <- 1, hit_o=1.
  - Miss: no state change, hit_o=0, victim outputs as for LOOKUP.
- FILL:
  - Hit: overwrites the hit way.
  - Miss: overwrites the victim way.
  - In both cases valid <- 1, tag <- tag_i, dirty <- dirty_i.
  - Victim outputs report the pre-overwrite contents; hit_o reports the pre-fill lookup.
- LRU update (LOOKUP hit, WRITE hit, any FILL):
  - Accessed way age <- 0.
  - Every way whose age is below the accessed way's old age increments.
  - Ages in a set remain a permutation of 0..WAYS-1 at all times.
- Flush FSM, states IDLE, SCAN, EVICT, DONE:
  - IDLE->SCAN on flush_i with no request accepted that cycle; a request takes priority and flush_i must be held until accepted.
  - SCAN visits entry (set s, way w) one per cycle, way-major within each set, sets 0..SETS-1.
  - A valid and dirty entry moves the FSM to EVICT. In EVICT, evict_valid_o=1 and evict_* are stable until evict_ready_i=1.
  - On handshake the entry's dirty bit clears and the FSM returns to SCAN at the next entry.
  - After the last entry, DONE for one cycle (flush_done_o=1), then IDLE.
  - The flush leaves valid bits and LRU ages unchanged.
  - req_ready_o=0 from SCAN entry through DONE; flush_i while busy is ignored.
- Reset mid-flush aborts immediately to IDLE with all lines invalid.

Decomposition:
- Shared package dcache_pkg holds:
  - op encodings OP_LOOKUP/OP_WRITE/OP_FILL
  - flush state enum
  - packed entry struct {valid, dirty, tag}
- One sub-module, dcache_lru_ages:
  - per-set age storage, victim select, age update
  - parametrised by SETS and WAYS

Test Plan (SETS=16, WAYS=4, TAG_W=23, LINE_W=256):
- Reset, then LOOKUP idx 3 tag 0x5 -> next cycle rsp_valid_o=1, hit_o=0, way_o=0, victim_valid_o=0.
- FILL idx 3 with tags 0x1..0x4 (dirty_i=0), then LOOKUP tag 0x3 -> hit_o=1, way_o=2, data_o = line filled for 0x3.
- After that sequence, LOOKUP tag 0x1, then FILL tag 0x9 -> victim_tag_o=0x2, way_o=1; subsequent LOOKUP 0x2 misses and LOOKUP 0x1 hits.
- WRITE hit tag 0x4 with data 0xAA.., FILL forces its eviction -> victim_dirty_o=1, data_o=0xAA..; WRITE to absent tag -> hit_o=0, array unchanged.
- Make dirty lines at (idx 0, way 1) and (idx 15, way 3), pulse flush_i with evict_ready_i low for 3 cycles -> two evictions in order, outputs stable while stalled, req_ready_o=0 throughout, one flush_done_o pulse; both lines then hit with victim_dirty_o=0 on a later miss.
- Assert rst_i mid-flush during EVICT -> evict_valid_o=0 and flush_busy_o=0 immediately; next LOOKUP misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared encodings and types for the N-way L1 data-cache array.
package dcache_pkg;

  localparam int unsigned TAG_MAX_W = 32;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_SCAN  = 2'd1,
    FL_EVICT = 2'd2,
    FL_DONE  = 2'd3
  } flush_state_e;

  // Tag is held zero-extended to TAG_MAX_W so one struct serves any TAG_W <= 32.
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } entry_t;

endpackage

// File: rtl/dcache_lru_ages.sv
// Per-set true-LRU age storage with victim selection and age update.
module dcache_lru_ages #(
  parameter int unsigned SETS = 16,
  parameter int unsigned WAYS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [$clog2(SETS)-1:0] idx_i,
  input  logic [WAYS-1:0]         valid_i,
  output logic [$clog2(WAYS)-1:0] victim_c,
  input  logic                    upd_en_i,
  input  logic [$clog2(SETS)-1:0] upd_idx_i,
  input  logic [$clog2(WAYS)-1:0] upd_way_i
);

  localparam int unsigned WAY_W = $clog2(WAYS);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] old_age;
  logic             found;

  // Lowest invalid way wins; otherwise the oldest way (age WAYS-1).
  always_comb begin
    victim_c = '0;
    found    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_i[w]) begin
        victim_c = WAY_W'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[idx_i][w] == WAY_W'(WAYS - 1)) victim_c = WAY_W'(w);
      end
    end
  end

  assign old_age = age_q[upd_idx_i][upd_way_i];

  // Accessed way becomes youngest; younger-than-old ways age by one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(WAYS - 1 - w);
        end
      end
    end else if (upd_en_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way_i) begin
          age_q[upd_idx_i][w] <= '0;
        end else if (age_q[upd_idx_i][w] < old_age) begin
          age_q[upd_idx_i][w] <= age_q[upd_idx_i][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dcache_nway_array.sv
// N-way set-associative L1 data/tag array with true-LRU and a dirty-line flush sweep.
module dcache_nway_array
  import dcache_pkg::*;
#(
  parameter int unsigned SETS   = 16,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned TAG_W  = 23,
  parameter int unsigned LINE_W = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [1:0]              op_i,
  input  logic [$clog2(SETS)-1:0] idx_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic [LINE_W-1:0]       data_i,
  input  logic                    dirty_i,
  output logic                    req_ready_o,
  output logic                    rsp_valid_o,
  output logic                    hit_o,
  output logic [$clog2(WAYS)-1:0] way_o,
  output logic [LINE_W-1:0]       data_o,
  output logic                    victim_valid_o,
  output logic                    victim_dirty_o,
  output logic [TAG_W-1:0]        victim_tag_o,
  input  logic                    flush_i,
  output logic                    flush_busy_o,
  output logic                    flush_done_o,
  output logic                    evict_valid_o,
  input  logic                    evict_ready_i,
  output logic [$clog2(SETS)-1:0] evict_idx_o,
  output logic [TAG_W-1:0]        evict_tag_o,
  output logic [LINE_W-1:0]       evict_data_o
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned PTR_W = IDX_W + WAY_W;
  localparam int unsigned ENT_N = SETS * WAYS;

  // Entry storage is addressed {set, way}, which is also the flush scan order.
  entry_t            ent_q  [ENT_N];
  logic [LINE_W-1:0] line_q [ENT_N];

  flush_state_e      state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              clr_dirty_c;

  logic              acc_c;
  logic              hit_c;
  logic [WAY_W-1:0]  hit_way_c;
  logic [WAYS-1:0]   valid_vec_c;
  logic [WAY_W-1:0]  victim_c;
  logic [WAY_W-1:0]  sel_way_c;
  logic [PTR_W-1:0]  sel_ptr_c;
  entry_t            sel_ent_c;
  entry_t            scan_ent_c;
  logic              wr_line_c;
  logic              upd_lru_c;
  logic              last_c;

  assign acc_c = req_i && req_ready_o;

  // Tag compare across the addressed set.
  always_comb begin
    hit_c       = 1'b0;
    hit_way_c   = '0;
    valid_vec_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_vec_c[w] = ent_q[{idx_i, WAY_W'(w)}].valid;
      if (ent_q[{idx_i, WAY_W'(w)}].valid &&
          ent_q[{idx_i, WAY_W'(w)}].tag == TAG_MAX_W'(tag_i)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
  end

  dcache_lru_ages #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx_i     (idx_i),
    .valid_i   (valid_vec_c),
    .victim_c  (victim_c),
    .upd_en_i  (upd_lru_c),
    .upd_idx_i (idx_i),
    .upd_way_i (sel_way_c)
  );

  assign sel_way_c  = hit_c ? hit_way_c : victim_c;
  assign sel_ptr_c  = {idx_i, sel_way_c};
  assign sel_ent_c  = ent_q[sel_ptr_c];
  assign scan_ent_c = ent_q[ptr_q];
  assign last_c     = (ptr_q == PTR_W'(ENT_N - 1));
  assign wr_line_c  = acc_c && ((op_i == OP_WRITE && hit_c) || op_i == OP_FILL);
  assign upd_lru_c  = acc_c && (((op_i == OP_LOOKUP || op_i == OP_WRITE) && hit_c) ||
                                op_i == OP_FILL);

  // Flush state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FL_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Flush next-state: a same-cycle request wins over flush_i.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    clr_dirty_c = 1'b0;
    case (state_q)
      FL_IDLE: begin
        if (flush_i && !acc_c) begin
          state_d = FL_SCAN;
          ptr_d   = '0;
        end
      end
      FL_SCAN: begin
        if (scan_ent_c.valid && scan_ent_c.dirty) begin
          state_d = FL_EVICT;
        end else if (last_c) begin
          state_d = FL_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      FL_EVICT: begin
        if (evict_ready_i) begin
          clr_dirty_c = 1'b1;
          if (last_c) begin
            state_d = FL_DONE;
          end else begin
            state_d = FL_SCAN;
            ptr_d   = ptr_q + 1'b1;
          end
        end
      end
      FL_DONE: state_d = FL_IDLE;
      default: state_d = FL_IDLE;
    endcase
  end

  // Valid/dirty/tag state; request writes and flush dirty-clears never overlap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENT_N; i++) ent_q[i] <= '0;
    end else if (acc_c && op_i == OP_WRITE && hit_c) begin
      ent_q[sel_ptr_c].dirty <= 1'b1;
    end else if (acc_c && op_i == OP_FILL) begin
      ent_q[sel_ptr_c] <= '{valid: 1'b1, dirty: dirty_i, tag: TAG_MAX_W'(tag_i)};
    end else if (clr_dirty_c) begin
      ent_q[ptr_q].dirty <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_line_c) line_q[sel_ptr_c] <= data_i;
  end

  // Registered response, flush status and eviction payload.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o    <= 1'b0;
      hit_o          <= 1'b0;
      way_o          <= '0;
      data_o         <= '0;
      victim_valid_o <= 1'b0;
      victim_dirty_o <= 1'b0;
      victim_tag_o   <= '0;
      req_ready_o    <= 1'b0;
      flush_busy_o   <= 1'b0;
      flush_done_o   <= 1'b0;
      evict_valid_o  <= 1'b0;
      evict_idx_o    <= '0;
      evict_tag_o    <= '0;
      evict_data_o   <= '0;
    end else begin
      rsp_valid_o <= acc_c;
      if (acc_c) begin
        hit_o          <= hit_c;
        way_o          <= sel_way_c;
        data_o         <= line_q[sel_ptr_c];
        victim_valid_o <= sel_ent_c.valid;
        victim_dirty_o <= sel_ent_c.dirty;
        victim_tag_o   <= TAG_W'(sel_ent_c.tag);
      end
      req_ready_o   <= (state_d == FL_IDLE);
      flush_busy_o  <= (state_d != FL_IDLE);
      flush_done_o  <= (state_d == FL_DONE);
      evict_valid_o <= (state_d == FL_EVICT);
      if (state_q == FL_SCAN && state_d == FL_EVICT) begin
        evict_idx_o  <= ptr_q[PTR_W-1:WAY_W];
        evict_tag_o  <= TAG_W'(scan_ent_c.tag);
        evict_data_o <= line_q[ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_dcache_nway_array.sv
// Scoreboarded bench for dcache_nway_array: reference cache model feeds expected responses.
module tb_dcache_nway_array;
  import dcache_pkg::*;

  localparam int unsigned SETS = 16, WAYS = 4, TAG_W = 23, LINE_W = 256;
  localparam int unsigned IDX_W = 4, WAY_W = 2;

  logic              clk_i = 1'b0, rst_i = 1'b1;
  logic              req_i = 1'b0, dirty_i = 1'b0, flush_i = 1'b0, evict_ready_i = 1'b0;
  logic [1:0]        op_i = '0;
  logic [IDX_W-1:0]  idx_i = '0;
  logic [TAG_W-1:0]  tag_i = '0;
  logic [LINE_W-1:0] data_i = '0;
  logic              req_ready_o, rsp_valid_o, hit_o, victim_valid_o, victim_dirty_o;
  logic              flush_busy_o, flush_done_o, evict_valid_o;
  logic [WAY_W-1:0]  way_o;
  logic [LINE_W-1:0] data_o, evict_data_o;
  logic [TAG_W-1:0]  victim_tag_o, evict_tag_o;
  logic [IDX_W-1:0]  evict_idx_o;

  always #5 clk_i = ~clk_i;

  dcache_nway_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .op_i(op_i), .idx_i(idx_i), .tag_i(tag_i),
    .data_i(data_i), .dirty_i(dirty_i), .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .hit_o(hit_o), .way_o(way_o), .data_o(data_o), .victim_valid_o(victim_valid_o),
    .victim_dirty_o(victim_dirty_o), .victim_tag_o(victim_tag_o), .flush_i(flush_i),
    .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o), .evict_valid_o(evict_valid_o),
    .evict_ready_i(evict_ready_i), .evict_idx_o(evict_idx_o), .evict_tag_o(evict_tag_o),
    .evict_data_o(evict_data_o)
  );

  typedef struct {
    int                cyc;
    logic              hit;
    logic [WAY_W-1:0]  way;
    logic [LINE_W-1:0] data;
    logic              chk_data;
    logic              vvalid;
    logic              vdirty;
    logic [TAG_W-1:0]  vtag;
  } rsp_t;

  typedef struct {
    int                idx;
    int                way;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } ev_t;

  rsp_t exp_q[$];
  int   checks = 0, errors = 0, cyc = 0;

  logic              m_valid [SETS][WAYS];
  logic              m_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];
  int                m_age   [SETS][WAYS];

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [LINE_W-1:0] pat(input logic [31:0] v);
    return {8{v}};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_age[s][w]   = WAYS - 1 - w;
      end
  endtask

  task automatic model_req(input logic [1:0] op, input int idx, input logic [TAG_W-1:0] tag,
                           input logic [LINE_W-1:0] data, input logic dirty, output rsp_t r);
    int hw = -1, vw = -1, sel, old;
    for (int w = 0; w < WAYS; w++) if (m_valid[idx][w] && m_tag[idx][w] == tag) hw = w;
    for (int w = 0; w < WAYS; w++) if (vw < 0 && !m_valid[idx][w]) vw = w;
    if (vw < 0) for (int w = 0; w < WAYS; w++) if (m_age[idx][w] == WAYS - 1) vw = w;
    sel        = (hw >= 0) ? hw : vw;
    r.hit      = (hw >= 0);
    r.way      = WAY_W'(sel);
    r.data     = m_data[idx][sel];
    r.chk_data = m_valid[idx][sel];
    r.vvalid   = m_valid[idx][sel];
    r.vdirty   = m_dirty[idx][sel];
    r.vtag     = m_tag[idx][sel];
    if (op == OP_WRITE && hw >= 0) begin
      m_data[idx][sel]  = data;
      m_dirty[idx][sel] = 1'b1;
    end
    if (op == OP_FILL) begin
      m_valid[idx][sel] = 1'b1;
      m_dirty[idx][sel] = dirty;
      m_tag[idx][sel]   = tag;
      m_data[idx][sel]  = data;
    end
    if (op == OP_FILL || ((op == OP_LOOKUP || op == OP_WRITE) && hw >= 0)) begin
      old = m_age[idx][sel];
      for (int w = 0; w < WAYS; w++)
        if (w == sel) m_age[idx][w] = 0;
        else if (m_age[idx][w] < old) m_age[idx][w] = m_age[idx][w] + 1;
    end
  endtask

  // Drive one request at the next falling edge and queue its expected response.
  task automatic issue(input logic [1:0] op, input int idx, input logic [TAG_W-1:0] tag,
                       input logic [LINE_W-1:0] data, input logic dirty);
    rsp_t r;
    @(negedge clk_i);
    model_req(op, idx, tag, data, dirty, r);
    r.cyc = cyc + 1;
    exp_q.push_back(r);
    req_i = 1'b1; op_i = op; idx_i = IDX_W'(idx); tag_i = tag; data_i = data; dirty_i = dirty;
  endtask

  task automatic idle();
    @(negedge clk_i);
    req_i = 1'b0;
    flush_i = 1'b0;
  endtask

  // Response scoreboard: every rsp_valid_o must match the oldest queued expectation.
  always @(negedge clk_i) begin
    rsp_t e;
    if (rsp_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid_o=1 with nothing outstanding at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || hit_o !== e.hit || way_o !== e.way || victim_valid_o !== e.vvalid ||
            victim_dirty_o !== e.vdirty || (e.vvalid && victim_tag_o !== e.vtag) ||
            (e.chk_data && data_o !== e.data)) begin
          errors++;
          $display("FAIL rsp: got cyc=%0d hit=%b way=%0d vv=%b vd=%b vtag=%h data=%h, want cyc=%0d hit=%b way=%0d vv=%b vd=%b vtag=%h data=%h",
                   cyc, hit_o, way_o, victim_valid_o, victim_dirty_o, victim_tag_o, data_o,
                   e.cyc, e.hit, e.way, e.vvalid, e.vdirty, e.vtag, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    #12;
    checks++;
    if ({rsp_valid_o, req_ready_o, hit_o, flush_busy_o, flush_done_o, evict_valid_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000",
               {rsp_valid_o, req_ready_o, hit_o, flush_busy_o, flush_done_o, evict_valid_o});
    end
    @(negedge clk_i); rst_i = 1'b0;
    idle();
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
    issue(OP_LOOKUP, 3, 23'h5, '0, 1'b0);
    idle();
    checks++;
    if (rsp_valid_o !== 1'b1 || hit_o !== 1'b0 || way_o !== 2'd0 || victim_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL first_lookup: got rv=%b hit=%b way=%0d vv=%b want 1 0 0 0",
               rsp_valid_o, hit_o, way_o, victim_valid_o);
    end
  endtask

  task automatic test_fill_hit();
    for (int t = 1; t <= 4; t++) issue(OP_FILL, 3, TAG_W'(t), pat(32'hC000_0000 | t), 1'b0);
    issue(OP_LOOKUP, 3, 23'h3, '0, 1'b0);
    idle();
    checks++;
    if (hit_o !== 1'b1 || way_o !== 2'd2 || data_o !== pat(32'hC000_0003)) begin
      errors++;
      $display("FAIL fill_hit: got hit=%b way=%0d data=%h want 1 2 %h", hit_o, way_o, data_o,
               pat(32'hC000_0003));
    end
  endtask

  task automatic test_lru();
    issue(OP_LOOKUP, 3, 23'h1, '0, 1'b0);
    issue(OP_FILL, 3, 23'h9, pat(32'hC000_0009), 1'b0);
    idle();
    checks++;
    if (hit_o !== 1'b0 || way_o !== 2'd1 || victim_tag_o !== 23'h2) begin
      errors++;
      $display("FAIL lru_victim: got hit=%b way=%0d vtag=%h want 0 1 2", hit_o, way_o, victim_tag_o);
    end
    issue(OP_LOOKUP, 3, 23'h2, '0, 1'b0);
    idle();
    checks++;
    if (hit_o !== 1'b0) begin errors++; $display("FAIL lru_evicted: got hit=%b want 0", hit_o); end
    issue(OP_LOOKUP, 3, 23'h1, '0, 1'b0);
    idle();
    checks++;
    if (hit_o !== 1'b1 || way_o !== 2'd0) begin
      errors++; $display("FAIL lru_kept: got hit=%b way=%0d want 1 0", hit_o, way_o);
    end
  endtask

  task automatic test_write_dirty();
    logic [LINE_W-1:0] aa;
    aa = {32{8'hAA}};
    issue(OP_WRITE, 3, 23'h4, aa, 1'b0);
    idle();
    checks++;
    if (hit_o !== 1'b1 || way_o !== 2'd3) begin
      errors++; $display("FAIL write_hit: got hit=%b way=%0d want 1 3", hit_o, way_o);
    end
    issue(OP_LOOKUP, 3, 23'h9, '0, 1'b0);
    issue(OP_LOOKUP, 3, 23'h1, '0, 1'b0);
    issue(OP_LOOKUP, 3, 23'h3, '0, 1'b0);
    issue(OP_FILL, 3, 23'h7, pat(32'hC000_0007), 1'b0);
    idle();
    checks++;
    if (victim_dirty_o !== 1'b1 || data_o !== aa || victim_tag_o !== 23'h4 || way_o !== 2'd3) begin
      errors++;
      $display("FAIL dirty_evict: got vd=%b vtag=%h way=%0d data=%h want 1 4 3 %h",
               victim_dirty_o, victim_tag_o, way_o, data_o, aa);
    end
    issue(OP_WRITE, 3, 23'h55, pat(32'h5555_5555), 1'b0);
    idle();
    checks++;
    if (hit_o !== 1'b0) begin errors++; $display("FAIL write_miss: got hit=%b want 0", hit_o); end
    issue(OP_LOOKUP, 3, 23'h1, '0, 1'b0);
    issue(OP_LOOKUP, 3, 23'h9, '0, 1'b0);
    issue(OP_LOOKUP, 3, 23'h3, '0, 1'b0);
    issue(OP_LOOKUP, 3, 23'h7, '0, 1'b0);
    issue(OP_LOOKUP, 3, 23'h55, '0, 1'b0);
    idle();
  endtask

  task automatic test_flush();
    ev_t ev[$];
    int  done_cnt = 0, n = 0;
    for (int t = 0; t < 4; t++)
      issue(OP_FILL, 0, TAG_W'(32'h10 + t), pat(32'hD000_0010 + t), (t == 1));
    for (int t = 0; t < 4; t++)
      issue(OP_FILL, 15, TAG_W'(32'h20 + t), pat(32'hD000_0020 + t), (t == 3));
    idle();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_dirty[s][w]) ev.push_back('{s, w, m_tag[s][w], m_data[s][w]});
    @(negedge clk_i); flush_i = 1'b1;
    @(negedge clk_i); flush_i = 1'b0;
    for (int k = 0; k < ev.size(); k++) begin
      n = 0;
      while (evict_valid_o !== 1'b1 && n < 200) begin
        checks++;
        if (req_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", req_ready_o); end
        @(negedge clk_i); n++;
      end
      checks++;
      if (n >= 200) begin errors++; $display("FAIL evict_timeout: eviction %0d never presented", k); break; end
      if (evict_idx_o !== IDX_W'(ev[k].idx) || evict_tag_o !== ev[k].tag || evict_data_o !== ev[k].data) begin
        errors++;
        $display("FAIL evict_payload: got idx=%0d tag=%h data=%h want idx=%0d tag=%h data=%h",
                 evict_idx_o, evict_tag_o, evict_data_o, ev[k].idx, ev[k].tag, ev[k].data);
      end
      req_i = 1'b1; op_i = OP_LOOKUP; flush_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk_i); flush_i = 1'b0;
        checks++;
        if (evict_valid_o !== 1'b1 || evict_idx_o !== IDX_W'(ev[k].idx) || evict_tag_o !== ev[k].tag ||
            evict_data_o !== ev[k].data || req_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL evict_stall: got ev=%b idx=%0d tag=%h rdy=%b want 1 %0d %h 0",
                   evict_valid_o, evict_idx_o, evict_tag_o, req_ready_o, ev[k].idx, ev[k].tag);
        end
      end
      req_i = 1'b0; evict_ready_i = 1'b1;
      @(negedge clk_i); evict_ready_i = 1'b0;
      m_dirty[ev[k].idx][ev[k].way] = 1'b0;
    end
    n = 0;
    while (flush_busy_o === 1'b1 && n < 300) begin
      if (flush_done_o === 1'b1) done_cnt++;
      checks++;
      if (req_ready_o !== 1'b0) begin errors++; $display("FAIL flush_busy_ready: got %b want 0", req_ready_o); end
      @(negedge clk_i); n++;
    end
    checks++;
    if (done_cnt != 1 || req_ready_o !== 1'b1 || flush_done_o !== 1'b0 || n >= 300) begin
      errors++;
      $display("FAIL flush_done: got pulses=%0d rdy=%b done=%b cycles=%0d want 1 1 0 <300",
               done_cnt, req_ready_o, flush_done_o, n);
    end
    for (int p = 0; p < 2; p++) begin
      int s, dw, b;
      s = (p == 0) ? 0 : 15; dw = (p == 0) ? 1 : 3; b = (p == 0) ? 32'h10 : 32'h20;
      issue(OP_LOOKUP, s, TAG_W'(b + dw), '0, 1'b0);
      idle();
      checks++;
      if (hit_o !== 1'b1 || victim_dirty_o !== 1'b0) begin
        errors++; $display("FAIL flush_clean_hit: set %0d got hit=%b vd=%b want 1 0", s, hit_o, victim_dirty_o);
      end
      for (int w = 0; w < WAYS; w++) if (w != dw) issue(OP_LOOKUP, s, TAG_W'(b + w), '0, 1'b0);
      issue(OP_LOOKUP, s, 23'h99, '0, 1'b0);
      idle();
      checks++;
      if (hit_o !== 1'b0 || way_o !== WAY_W'(dw) || victim_dirty_o !== 1'b0 || victim_tag_o !== TAG_W'(b + dw)) begin
        errors++;
        $display("FAIL flush_clean_victim: set %0d got hit=%b way=%0d vd=%b vtag=%h want 0 %0d 0 %h",
                 s, hit_o, way_o, victim_dirty_o, victim_tag_o, dw, b + dw);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [LINE_W-1:0] d;
    for (int i = 0; i < 200; i++) begin
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
      issue(2'($urandom_range(0, 2)), $urandom_range(0, 3), TAG_W'($urandom_range(1, 6)), d,
            1'($urandom_range(0, 1)));
    end
    idle();
  endtask

  task automatic test_reset_mid_flush();
    int n = 0;
    issue(OP_FILL, 7, 23'h3ff, pat(32'hBEEF_0007), 1'b1);
    idle();
    @(negedge clk_i); flush_i = 1'b1;
    @(negedge clk_i); flush_i = 1'b0;
    while (evict_valid_o !== 1'b1 && n < 200) begin @(negedge clk_i); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL midflush_evict: never reached eviction"); end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (evict_valid_o !== 1'b0 || flush_busy_o !== 1'b0 || req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midflush_reset: got ev=%b busy=%b rdy=%b want 0 0 0", evict_valid_o, flush_busy_o, req_ready_o);
    end
    model_reset();
    @(negedge clk_i); rst_i = 1'b0;
    idle();
    issue(OP_LOOKUP, 7, 23'h3ff, '0, 1'b0);
    idle();
    checks++;
    if (hit_o !== 1'b0 || victim_valid_o !== 1'b0) begin
      errors++; $display("FAIL midflush_lookup: got hit=%b vv=%b want 0 0", hit_o, victim_valid_o);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_hit();
    test_lru();
    test_write_dirty();
    test_flush();
    test_back_to_back();
    test_reset_mid_flush();
    repeat (2) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rsp_missing: %0d responses never arrived, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
